// File: rtl/piso_encoder_pkg.sv
// Shared definitions for the PISO transmitter and its SIPO peer.
package piso_encoder_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int GAP_CYCLES_DEF = 1;

  // Bit order on the wire; the SIPO receiver assumes the same convention.
  localparam bit LSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Counter width for a mod-n counter (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_encoder_frame_counter.sv
// Mod-N up-counter with synchronous active-low clear, enable and terminal count.
module frame_counter
  import piso_encoder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic clk_i,
  input  logic clr_n_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = cnt_w(N);

  logic [W-1:0] cnt_q;

  assign tc_o = (cnt_q == W'(N - 1));

  // Count on enable and wrap to zero after the terminal value.
  always_ff @(posedge clk_i) begin
    if (!clr_n_i)  cnt_q <= '0;
    else if (en_i) cnt_q <= tc_o ? '0 : cnt_q + W'(1);
  end

endmodule

// File: rtl/piso_encoder.sv
// Parallel-in/serial-out transmitter: skid buffer, shift FSM, idle gap.
module piso_encoder
  import piso_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  dataValid,
  output logic                  dataReady,
  output logic                  serialOut,
  output logic                  frameStart,
  output logic                  busy
);

  // The gap counter still needs a legal modulus when no gap is configured.
  localparam int GAP_N = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_full_q;
  logic                  serial_q;
  logic                  frame_start_q;

  logic                  accept;
  logic                  reload;
  logic                  bit_tc;
  logic                  gap_tc;
  logic                  first_bit;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] shift_d;

  assign dataReady  = resetN && !hold_full_q;
  assign accept     = dataValid && dataReady;
  assign busy       = (state_q != ST_IDLE) || hold_full_q;
  assign serialOut  = serial_q;
  assign frameStart = frame_start_q;

  // Bit-order dependent taps: the bit that goes out first, and the one after the current.
  assign first_bit = LSB_FIRST ? hold_q[0]  : hold_q[DATA_WIDTH-1];
  assign next_bit  = LSB_FIRST ? shift_q[1] : shift_q[DATA_WIDTH-2];
  assign shift_d   = LSB_FIRST ? (shift_q >> 1) : (shift_q << 1);

  // Both counters wrap on their own terminal count, so reset is the only clear needed.
  frame_counter #(.N(DATA_WIDTH)) u_bit_cnt (
    .clk_i   (clock),
    .clr_n_i (resetN),
    .en_i    (state_q == ST_SHIFT),
    .tc_o    (bit_tc)
  );

  frame_counter #(.N(GAP_N)) u_gap_cnt (
    .clk_i   (clock),
    .clr_n_i (resetN),
    .en_i    (state_q == ST_GAP),
    .tc_o    (gap_tc)
  );

  // A frame may start from IDLE, straight after the last bit when there is no gap, or at gap end.
  always_comb begin
    reload = 1'b0;
    case (state_q)
      ST_IDLE:  reload = hold_full_q;
      ST_SHIFT: reload = bit_tc && (GAP_CYCLES == 0) && hold_full_q;
      ST_GAP:   reload = gap_tc && hold_full_q;
      default:  reload = 1'b0;
    endcase
  end

  // Transmit FSM with holding buffer and registered serial outputs.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      serial_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      if (accept) hold_q <= dataIn;
      // Accept wins over reload so a byte arriving on a reload edge is kept.
      if (accept)      hold_full_q <= 1'b1;
      else if (reload) hold_full_q <= 1'b0;

      frame_start_q <= 1'b0;
      if (reload) begin
        state_q       <= ST_SHIFT;
        shift_q       <= hold_q;
        serial_q      <= first_bit;
        frame_start_q <= 1'b1;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            if (bit_tc) begin
              state_q  <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
              serial_q <= 1'b0;
            end else begin
              shift_q  <= shift_d;
              serial_q <= next_bit;
            end
          end
          ST_GAP: begin
            if (gap_tc) state_q <= ST_IDLE;
            serial_q <= 1'b0;
          end
          default: begin
            state_q  <= ST_IDLE;
            serial_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_encoder.sv
// Bench: two encoders (gap 1 and gap 0) against a frame-schedule reference model.
module tb_piso_encoder;

  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          resetN;
  logic [DW-1:0] din [2];
  logic          dv  [2];
  logic          rdy [2];
  logic          so  [2];
  logic          fs  [2];
  logic          bsy [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  piso_encoder #(.DATA_WIDTH(DW), .GAP_CYCLES(1)) u_g1 (
    .clock(clock), .resetN(resetN), .dataIn(din[0]), .dataValid(dv[0]),
    .dataReady(rdy[0]), .serialOut(so[0]), .frameStart(fs[0]), .busy(bsy[0]));

  piso_encoder #(.DATA_WIDTH(DW), .GAP_CYCLES(0)) u_g0 (
    .clock(clock), .resetN(resetN), .dataIn(din[1]), .dataValid(dv[1]),
    .dataReady(rdy[1]), .serialOut(so[1]), .frameStart(fs[1]), .busy(bsy[1]));

  // Stimulus byte list shared by both instances; each has its own read pointer.
  logic [DW-1:0] stim[$];
  int            rd[2];
  int            stall_pct = 0;

  // Reference model: the frame currently on the wire plus the byte waiting for its slot.
  int            gap[2] = '{1, 0};
  int            cyc = 0;
  bit            cur_v[2];
  int            cur_s[2];
  logic [DW-1:0] cur_b[2];
  bit            hf[2];
  logic [DW-1:0] hb[2];
  int            hs[2];

  task automatic check_bit(input string tag, input int i, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[g%0d] cyc %0d got %b exp %b", tag, gap[i], cyc, got, exp);
    end
  endtask

  function automatic bit model_idle(input int i);
    return !hf[i] && (!cur_v[i] || cyc >= cur_s[i] + DW + gap[i]);
  endfunction

  task automatic step(input bit rst_n, input bit allow);
    bit            acc;
    int            e;
    int            k;
    logic          exp_so;
    resetN = rst_n;
    for (int i = 0; i < 2; i++) begin
      dv[i]  = allow && (rd[i] < stim.size()) && ($urandom_range(0, 99) >= stall_pct);
      din[i] = dv[i] ? stim[rd[i]] : DW'($urandom);
    end
    @(posedge clock);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      acc = dv[i] && rst_n && !hf[i];
      if (!rst_n) begin
        cur_v[i] = 1'b0;
        hf[i]    = 1'b0;
      end else begin
        if (hf[i] && hs[i] == cyc) begin
          cur_v[i] = 1'b1;
          cur_s[i] = cyc;
          cur_b[i] = hb[i];
          hf[i]    = 1'b0;
        end
        if (acc) begin
          e      = cur_s[i] + DW + gap[i];
          hf[i]  = 1'b1;
          hb[i]  = din[i];
          hs[i]  = (cur_v[i] && e > cyc + 1) ? e : cyc + 1;
          rd[i]++;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      k      = cyc - cur_s[i];
      exp_so = (cur_v[i] && k >= 0 && k < DW) ? cur_b[i][k] : 1'b0;
      check_bit("serialOut", i, so[i], exp_so);
      check_bit("frameStart", i, fs[i], cur_v[i] && k == 0);
      check_bit("busy", i, bsy[i], hf[i] || (cur_v[i] && k < DW + gap[i]));
      check_bit("dataReady", i, rdy[i], rst_n && !hf[i]);
    end
  endtask

  task automatic run_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      step(1'b1, 1'b1);
      done = (rd[0] == stim.size()) && (rd[1] == stim.size()) && model_idle(0) && model_idle(1);
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("FAIL timeout %s got not-idle exp idle within 600 cycles", tag);
    end
  endtask

  initial begin
    resetN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dv[i] = 1'b0; din[i] = '0; rd[i] = 0;
      cur_v[i] = 1'b0; cur_s[i] = 0; cur_b[i] = '0; hf[i] = 1'b0; hb[i] = '0; hs[i] = 0;
    end

    // Reset held with a valid byte on the inputs: nothing is accepted.
    stim.push_back(8'hEE);
    repeat (3) step(1'b0, 1'b1);
    rd[0] = stim.size(); rd[1] = stim.size();
    repeat (2) step(1'b1, 1'b0);

    // Single byte, then idle with busy low.
    stim.push_back(8'hA5);
    run_idle("single");
    repeat (2) step(1'b1, 1'b0);

    // Back-to-back stream with valid held high.
    stim.push_back(8'h01); stim.push_back(8'hFF); stim.push_back(8'h80);
    run_idle("b2b");

    // Gap-0 seamless pair (also sent through the gap-1 instance).
    stim.push_back(8'hF0); stim.push_back(8'h0F);
    run_idle("gap0");

    // Reset during bit 4 of 8'h3C with another byte waiting in the holding buffer.
    stim.push_back(8'h3C); stim.push_back(8'h99);
    for (int n = 0; n < 50 && !(cur_v[0] && cyc - cur_s[0] == 4); n++) step(1'b1, 1'b1);
    checks++;
    assert (cur_v[0] && cyc - cur_s[0] == 4) else begin
      errors++;
      $error("FAIL reach_bit4 got offset %0d exp 4", cyc - cur_s[0]);
    end
    step(1'b0, 1'b0);
    rd[0] = stim.size(); rd[1] = stim.size();
    step(1'b1, 1'b0);
    stim.push_back(8'h55);
    run_idle("post_reset");

    // Randomized traffic with random valid stalls.
    for (int r = 0; r < 3; r++) begin
      stall_pct = r * 30;
      for (int n = 0; n < 12; n++) stim.push_back(DW'($urandom));
      run_idle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
